// File: rtl/uart_tx_fifo.sv
// Byte FIFO and frame issue controller feeding a UART transmitter over tx_write/tx_data/tx_finished.
// Define UART_TX_CTS_EN to add the n_cts port and gate frame issue on synchronized clear-to-send.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          busy,
  output logic          tx_write,
  output logic [7:0]    tx_data,
  input  logic          tx_finished
`ifdef UART_TX_CTS_EN
  ,
  input  logic          n_cts
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_next;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        push, issue, cts_ok;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr_en && !full;

`ifdef UART_TX_CTS_EN
  logic cts_meta, cts_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= n_cts;
      cts_sync <= cts_meta;
    end
  end

  assign cts_ok = !cts_sync;
`else
  assign cts_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty && cts_ok) state_next = WAIT;
      WAIT:    if (tx_finished)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue = (state == IDLE) && !empty && cts_ok;
    busy  = (state == WAIT);
  end

  // Storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      tx_write <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (push)           wr_ptr   <= wr_ptr + 1'b1;
      if (wr_en && full)  overflow <= 1'b1;
      tx_write <= issue;
      if (issue) begin
        tx_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
